adder_arbiter: RTL
==================

// Module: adder_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 32-bit adder datapath among NUM_REQ requesters.
//  Each granted operation is executed twice on consecutive cycles; the two results are compared
//  to catch transient datapath faults, with bounded retry. Sits between client blocks and the
//  single adder instance; the adder is combinational and external, so all sequencing lives here.
// PARAMETERS
//  NUM_REQ    4   number of requesters (2..16)
//  WIDTH      32  operand/sum width; must match the adder
//  MAX_RETRY  3   re-executions allowed after a mismatch before reporting an error (0..15)
// PORTS
//  clk        in   1              clock
//  reset      in   1              synchronous, active-high
//  req_valid  in   NUM_REQ        per-requester operation valid
//  req_ready  out  NUM_REQ        per-requester accept, one-hot or zero
//  req_a      in   NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b      in   NUM_REQ*WIDTH  operand B, same packing
//  rsp_valid  out  1              response valid
//  rsp_ready  in   1              response consumer ready
//  rsp_id     out  $clog2(NUM_REQ) index of the requester owning the response
//  rsp_sum    out  WIDTH          agreed sum; last (second) sample if rsp_err=1
//  rsp_err    out  1              retries exhausted without two matching results
//  add_a      out  WIDTH          to adder operand A
//  add_b      out  WIDTH          to adder operand B
//  add_s      in   WIDTH          from adder sum (combinational from add_a/add_b)
//  fault_cnt  out  16             saturating count of mismatches detected
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=NUM_REQ-1, req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0,
//   rsp_err=0, fault_cnt=0, add_a=add_b=0, retry_cnt=0.
//  FSM states: IDLE -> EXEC1 -> EXEC2 -> {EXEC1 | RESP} -> IDLE.
//  IDLE: the first requester with req_valid set is chosen, scanning from rr_ptr+1 modulo NUM_REQ.
//   req_ready[g] is asserted combinationally in that cycle; nothing else is asserted.
//   On that edge: operands are latched, id=g, rr_ptr=g, retry_cnt=0, and the FSM enters EXEC1.
//   req_ready is 0 in all non-IDLE states.
//  EXEC1: add_a/add_b = latched operands; add_s is captured into s0; FSM enters EXEC2.
//  EXEC2: same operands; add_s is captured into s1.
//   If s0==s1: rsp_sum=s1, rsp_err=0, enter RESP.
//   If s0!=s1: fault_cnt++ (saturates at 16'hFFFF). If retry_cnt<MAX_RETRY: retry_cnt++, enter EXEC1.
//   Otherwise rsp_sum=s1, rsp_err=1, enter RESP.
//  add_a/add_b are 0 in IDLE and RESP.
//  RESP: rsp_valid=1; rsp_id/rsp_sum/rsp_err are stable until rsp_valid&&rsp_ready, then enter IDLE.
//   rsp_valid never depends combinationally on rsp_ready.
//  Latency: accept at edge T -> rsp_valid high from T+3 with no fault; each retry adds 2 cycles.
//   One operation is in flight at a time; a new grant is possible the cycle after the response handshake.
//  Arithmetic: sum modulo 2^WIDTH, carry-out discarded; comparison is full-width equality.
//  Fairness: a continuously valid requester is granted within NUM_REQ grants.
//   Requests may drop without handshake; dropping is not an error.
//  Reset mid-operation: abandons the op silently, no response; all state returns to reset values.
//  Simultaneous reset and req_valid: reset wins, and no req_ready is asserted in that cycle.
// STRUCTURE
//  adder_arb_pkg: typedef enum {IDLE,EXEC1,EXEC2,RESP} arb_state_t; default width constant.
//  Sub-module rr_picker: combinational round-robin select (req vector, ptr -> one-hot grant, index).
//  The adder instance lives outside this block and is wired in by the parent.
// TESTING
//  1 Single op: reset, req0 a=5 b=7 -> req_ready[0] same cycle; rsp_valid 3 cycles later;
//    rsp_sum=12, rsp_id=0, rsp_err=0.
//  2 Wrap: a=32'hFFFF_FFFF b=2 -> rsp_sum=1, rsp_err=0.
//  3 RR fairness: all 4 valid continuously from reset -> grant order 0,1,2,3,0; no grant duplicated
//    inside a window of 4.
//  4 Transient fault: adder model returns 32'hDEAD_BEEF on one cycle, e.g. the EXEC2 sample ->
//    one retry; correct sum; rsp_err=0; fault_cnt=1; latency 5.
//  5 Persistent fault: adder model always mismatches, MAX_RETRY=3 -> 4 compares; rsp_err=1;
//    fault_cnt=4.
//  6 Backpressure and reset: hold rsp_ready=0 for 10 cycles -> outputs stable and no new grant.
//    Then assert reset in EXEC2 -> no response; the next op from req2 completes normally.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the duplicated-execution adder arbiter.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int          DEFAULT_WIDTH   = 32;
    localparam int          DEFAULT_NUM_REQ = 4;
    localparam int          DEFAULT_RETRY   = 3;
    localparam logic [15:0] FAULT_CNT_MAX   = 16'hFFFF;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set bit of req scanning upward from ptr+1, wrapping.
// Zero latency; no backpressure (pure function of req and ptr).
module rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        // k runs 1..NUM_REQ so the last candidate examined is ptr itself
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of one external adder; each op runs twice and results are compared, with bounded retry.
// Latency: response valid 3 cycles after the grant cycle, plus 2 cycles per retry; one op in flight.
// Backpressure: RESP holds its outputs until rsp_ready; no new grant is issued until the response handshake.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int NUM_REQ   = DEFAULT_NUM_REQ,
    parameter  int WIDTH     = DEFAULT_WIDTH,
    parameter  int MAX_RETRY = DEFAULT_RETRY,
    localparam int IW        = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IW-1:0]            rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_err,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH-1:0]         add_s,
    output logic [15:0]              fault_cnt
);

    arb_state_t         state, state_nxt;
    logic [IW-1:0]      rr_ptr;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [WIDTH-1:0]   s0;
    logic [3:0]         retry_cnt;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               mismatch;
    logic               retry_ok;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // In EXEC2 the live adder output is the second sample
    assign mismatch = (s0 != add_s);
    assign retry_ok = (int'(retry_cnt) < MAX_RETRY);

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        case (state)
            IDLE: begin
                // reset gates the grant so a same-cycle reset never shows a req_ready
                if (pick_any && !reset) begin
                    req_ready = pick_grant;
                    state_nxt = EXEC1;
                end
            end
            EXEC1: begin
                add_a     = op_a;
                add_b     = op_b;
                state_nxt = EXEC2;
            end
            EXEC2: begin
                add_a     = op_a;
                add_b     = op_b;
                state_nxt = (mismatch && retry_ok) ? EXEC1 : RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= IW'(NUM_REQ - 1);
            op_a      <= '0;
            op_b      <= '0;
            s0        <= '0;
            retry_cnt <= '0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_err   <= 1'b0;
            fault_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        op_a      <= req_a[int'(pick_idx)*WIDTH +: WIDTH];
                        op_b      <= req_b[int'(pick_idx)*WIDTH +: WIDTH];
                        rsp_id    <= pick_idx;
                        rr_ptr    <= pick_idx;
                        retry_cnt <= '0;
                    end
                end
                EXEC1: begin
                    s0 <= add_s;
                end
                EXEC2: begin
                    if (mismatch) begin
                        if (fault_cnt != FAULT_CNT_MAX) begin
                            fault_cnt <= fault_cnt + 16'd1;
                        end
                        if (retry_ok) begin
                            retry_cnt <= retry_cnt + 4'd1;
                        end else begin
                            rsp_sum <= add_s;
                            rsp_err <= 1'b1;
                        end
                    end else begin
                        rsp_sum <= add_s;
                        rsp_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
